smu_bitstream_serializer: RTL and testbench
===========================================

SMU_BITSTREAM_SERIALIZER -- requirements
Module: smu_bitstream_serializer

Interface
REQ-001 SHALL have parameter CFG_SIZE, default 100: number of configuration bits per frame (legal range >= 1).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-low (asserted when 0).
REQ-004 SHALL have port ParallelIn, input, CFG_SIZE: configuration word to transmit; sampled only when a Start is accepted.
REQ-005 SHALL have port Start, input, 1: load request; takes effect only in IDLE.
REQ-006 SHALL have port StreamEn, input, 1: per-cycle permission to emit a bit; low means stall.
REQ-007 SHALL have port SerialOut, output, 1: current serial data bit, matching the deserializer SerialIn.
REQ-008 SHALL have port StreamValid, output, 1: SerialOut is valid this cycle, matching the deserializer StreamValid.
REQ-009 SHALL have port Busy, output, 1: high whenever the state is not IDLE.
REQ-010 SHALL have port CfgSent, output, 1: single-cycle pulse after the last bit has been emitted.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 IDLE: Start=1 SHALL load ShiftReg<=ParallelIn, clear BitCount<=0 and move to SHIFT on the next edge; Start=0 SHALL stay in IDLE.
REQ-013 ShiftReg SHALL be CFG_SIZE bits wide and BitCount SHALL be $clog2(CFG_SIZE+1) bits wide; BitCount SHALL never exceed CFG_SIZE-1.
REQ-014 SerialOut SHALL equal ShiftReg[CFG_SIZE-1] in every state, so bits go out MSB first.
- Rationale: the receiver shifts left with new bits entering the LSB, so MSB-first transmission makes receiver ParallelOut equal ParallelIn.
REQ-015 StreamValid SHALL be combinational: (state==SHIFT) AND StreamEn, and 0 in IDLE and DONE.
REQ-016 SHIFT with StreamValid=1 SHALL shift ShiftReg left by one bit, fill the LSB with 0, and increment BitCount.
REQ-017 SHIFT with StreamEn=0 SHALL hold ShiftReg, BitCount and state unchanged, with no limit on stall length.
REQ-018 SHIFT with StreamValid=1 and BitCount==CFG_SIZE-1 SHALL move to DONE; that cycle carries the last bit.
REQ-019 DONE SHALL drive CfgSent=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-020 Start SHALL be ignored in SHIFT and DONE, including in the DONE cycle itself; ParallelIn changes SHALL have no effect outside an accepted Start.
REQ-021 Latency with no stalls: Start accepted at edge 0 -> bits valid in cycles 1..CFG_SIZE -> CfgSent in cycle CFG_SIZE+1 -> IDLE in cycle CFG_SIZE+2, where a new Start may be accepted. Each stall cycle adds one cycle.
REQ-022 CFG_SIZE=1 SHALL work: exactly one valid bit, then DONE.
REQ-023 Exactly CFG_SIZE cycles with StreamValid=1 SHALL occur per accepted Start, never more and never fewer.

Reset
REQ-024 On rst=0 at a clock edge, regardless of state: state<=IDLE, ShiftReg<=0, BitCount<=0.
REQ-025 During and after reset: SerialOut=0, StreamValid=0, Busy=0, CfgSent=0.
REQ-026 Reset mid-SHIFT SHALL abort the frame with no CfgSent pulse; the next Start SHALL begin a fresh frame from bit CFG_SIZE-1.
REQ-027 Start asserted in the same cycle as rst=0 SHALL be ignored.

Verification (CFG_SIZE=8 unless stated)
REQ-028 ParallelIn=8'hA5, Start pulse, StreamEn=1 -> SerialOut 1,0,1,0,0,1,0,1 in cycles 1..8 with StreamValid=1; CfgSent in cycle 9; Busy high in cycles 1..9.
REQ-029 Loopback into smu_bitstream_deserializer (CFG_SIZE=8), ParallelIn=8'h3C -> receiver ParallelOut=8'h3C and CfgDone=1 in the cycle CfgSent=1.
REQ-030 8'hFF with StreamEn low in cycles 2, 3 and 6 -> StreamValid=0 and SerialOut held in those cycles; still exactly 8 valid bits; CfgSent in cycle 12.
REQ-031 Start held high continuously with 8'h81, then ParallelIn changed to 8'h00 in cycle 3 -> frame still emits 8'h81; next frame accepted in cycle 10 (the first IDLE cycle, cycle 10 = CFG_SIZE+2) and carries 8'h00.
REQ-032 rst=0 in cycle 4 of a frame -> from cycle 5 all outputs 0 and no CfgSent; a new Start with 8'h5A transmits correctly.
REQ-033 CFG_SIZE=1, ParallelIn=1 -> one valid bit of 1 in cycle 1; CfgSent in cycle 2; IDLE in cycle 3.

Source files
------------

// File: rtl/smu_bitstream_serializer.sv
// Frame serializer: loads a CFG_SIZE-bit configuration word on Start and
// shifts it out MSB first, one bit per cycle in which StreamEn permits.
module smu_bitstream_serializer #(
  parameter int CFG_SIZE = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CFG_SIZE-1:0] ParallelIn,
  input  logic                Start,
  input  logic                StreamEn,
  output logic                SerialOut,
  output logic                StreamValid,
  output logic                Busy,
  output logic                CfgSent
);

  localparam int CW = $clog2(CFG_SIZE + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CFG_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CFG_SIZE-1:0] shift_q, shift_d;
  logic [CW-1:0]       cnt_q,   cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    StreamValid = 1'b0;
    CfgSent     = 1'b0;
    Busy        = (state_q != IDLE);
    SerialOut   = shift_q[CFG_SIZE-1];

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          shift_d = ParallelIn;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        StreamValid = StreamEn;
        // A stalled cycle leaves every register untouched.
        if (StreamEn) begin
          shift_d = shift_q << 1;
          if (cnt_q == LAST_BIT) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        CfgSent = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_smu_bitstream_serializer.sv
// Directed bench for smu_bitstream_serializer (CFG_SIZE=8 and CFG_SIZE=1).
module tb_smu_bitstream_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin;
  logic       start, en;
  logic       so, sv, busy, sent;

  logic [0:0] pin1;
  logic       start1, en1;
  logic       so1, sv1, busy1, sent1;

  logic [7:0] rx;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  smu_bitstream_serializer #(.CFG_SIZE(8)) dut (
    .clk(clk), .rst(rst), .ParallelIn(pin), .Start(start), .StreamEn(en),
    .SerialOut(so), .StreamValid(sv), .Busy(busy), .CfgSent(sent)
  );

  smu_bitstream_serializer #(.CFG_SIZE(1)) dut1 (
    .clk(clk), .rst(rst), .ParallelIn(pin1), .Start(start1), .StreamEn(en1),
    .SerialOut(so1), .StreamValid(sv1), .Busy(busy1), .CfgSent(sent1)
  );

  // Receiver model: shifts left, new bit into the LSB on each valid cycle.
  always_ff @(posedge clk) begin
    if (!rst) rx <= '0;
    else if (sv) rx <= {rx[6:0], so};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; pin = 8'hFF; en = 1'b1;
    start1 = 1'b1; pin1 = 1'b1; en1 = 1'b1;
    step(); step();
    smp();
    checks++;
    if ({so, sv, busy, sent} !== 4'b0000) begin
      fails++; $display("FAIL reset_outs got=%b want=0000", {so, sv, busy, sent});
    end
    checks++;
    if ({so1, sv1, busy1, sent1} !== 4'b0000) begin
      fails++; $display("FAIL reset_outs_c1 got=%b want=0000", {so1, sv1, busy1, sent1});
    end
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    step();
    smp();
    checks++;
    if ({so, sv, busy, sent} !== 4'b0000) begin
      fails++; $display("FAIL reset_start_ignored got=%b want=0000", {so, sv, busy, sent});
    end
    step();
  endtask

  task automatic test_a5();
    logic [7:0] d;
    d = 8'hA5;
    pin = d; start = 1'b1; en = 1'b1;
    step();
    start = 1'b0; pin = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      smp();
      checks++;
      if (c <= 8) begin
        if ({sv, busy, sent, so} !== {3'b110, d[8-c]}) begin
          fails++; $display("FAIL a5_bit c=%0d got v/b/s/o=%b want=%b", c, {sv, busy, sent, so}, {3'b110, d[8-c]});
        end
      end else if (c == 9) begin
        if ({sv, busy, sent} !== 3'b011) begin
          fails++; $display("FAIL a5_done got=%b want=011", {sv, busy, sent});
        end
      end else begin
        if ({sv, busy, sent} !== 3'b000) begin
          fails++; $display("FAIL a5_idle got=%b want=000", {sv, busy, sent});
        end
      end
      step();
    end
  endtask

  task automatic test_loopback();
    pin = 8'h3C; start = 1'b1; en = 1'b1;
    step();
    start = 1'b0; pin = 8'hFF;
    for (int c = 1; c <= 9; c++) begin
      smp();
      if (c == 9) begin
        checks++;
        if (sent !== 1'b1 || rx !== 8'h3C) begin
          fails++; $display("FAIL loopback got sent=%b rx=%h want sent=1 rx=3c", sent, rx);
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [12:1] exp_v;
    int nvalid;
    exp_v = 12'b011111011001; // bit c-1 => cycle c; stalls in cycles 2,3,6
    nvalid = 0;
    pin = 8'hFF; start = 1'b1; en = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      en = !(c == 2 || c == 3 || c == 6);
      smp();
      if (sv) nvalid++;
      checks++;
      if (sv !== exp_v[c] || (c <= 11 && so !== 1'b1) || sent !== (c == 12) || busy !== (c <= 12)) begin
        fails++; $display("FAIL stall c=%0d got v=%b o=%b s=%b b=%b want v=%b", c, sv, so, sent, busy, exp_v[c]);
      end
      step();
    end
    en = 1'b1;
    checks++;
    if (nvalid != 8) begin
      fails++; $display("FAIL stall_count got=%0d want=8", nvalid);
    end
  endtask

  task automatic test_start_held();
    logic [7:0] d;
    pin = 8'h81; start = 1'b1; en = 1'b1;
    step();
    for (int c = 1; c <= 19; c++) begin
      if (c == 3) pin = 8'h00;
      d = (c <= 9) ? 8'h81 : 8'h00;
      smp();
      checks++;
      if (c <= 8 || (c >= 11 && c <= 18)) begin
        if ({sv, busy, sent, so} !== {3'b110, d[(c <= 8) ? 8 - c : 18 - c]}) begin
          fails++; $display("FAIL held_bit c=%0d got=%b want=%b", c, {sv, busy, sent, so}, {3'b110, d[(c <= 8) ? 8 - c : 18 - c]});
        end
      end else if (c == 9 || c == 19) begin
        if ({sv, busy, sent} !== 3'b011) begin
          fails++; $display("FAIL held_done c=%0d got=%b want=011", c, {sv, busy, sent});
        end
      end else begin
        if ({sv, busy, sent} !== 3'b000) begin
          fails++; $display("FAIL held_idle c=%0d got=%b want=000", c, {sv, busy, sent});
        end
      end
      step();
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    pin = 8'hFF; start = 1'b1; en = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      rst = (c != 4);
      smp();
      checks++;
      if (c <= 4) begin
        if ({sv, busy, so} !== 3'b111) begin
          fails++; $display("FAIL rstmid_pre c=%0d got=%b want=111", c, {sv, busy, so});
        end
      end else if ({so, sv, busy, sent} !== 4'b0000) begin
        fails++; $display("FAIL rstmid_post c=%0d got=%b want=0000", c, {so, sv, busy, sent});
      end
      step();
    end
    rst = 1'b1;
    d = 8'h5A;
    pin = d; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      smp();
      checks++;
      if (c <= 8) begin
        if ({sv, sent, so} !== {2'b10, d[8-c]}) begin
          fails++; $display("FAIL rstmid_5a c=%0d got=%b want=%b", c, {sv, sent, so}, {2'b10, d[8-c]});
        end
      end else if (sent !== 1'b1 || rx !== 8'h5A) begin
        fails++; $display("FAIL rstmid_5a_done got sent=%b rx=%h want 1 5a", sent, rx);
      end
      step();
    end
    step();
  endtask

  task automatic test_cfg1();
    pin1 = 1'b1; start1 = 1'b1; en1 = 1'b1;
    step();
    start1 = 1'b0; pin1 = 1'b0;
    smp();
    checks++;
    if ({sv1, busy1, sent1, so1} !== 4'b1101) begin
      fails++; $display("FAIL c1_bit got=%b want=1101", {sv1, busy1, sent1, so1});
    end
    step(); smp();
    checks++;
    if ({sv1, busy1, sent1} !== 3'b011) begin
      fails++; $display("FAIL c1_done got=%b want=011", {sv1, busy1, sent1});
    end
    step(); smp();
    checks++;
    if ({sv1, busy1, sent1} !== 3'b000) begin
      fails++; $display("FAIL c1_idle got=%b want=000", {sv1, busy1, sent1});
    end
    step();
  endtask

  initial begin
    test_reset();
    test_a5();
    test_loopback();
    test_stall();
    test_start_held();
    test_reset_mid();
    test_cfg1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
